key_press_conditioner: RTL and testbench
========================================

Name: key_press_conditioner

Overview:
- Synchronous front end for the board pushbuttons; drives the green LEDs.
- Synchronises the raw active-low KEY inputs, debounces each one, and emits one-cycle press and release pulses.
- Keeps one toggle bit per key and drives the LEDs from the XOR of all toggles, so any key flips the light.
- Replaces edge-triggering directly on button levels with a single-clock, glitch-free path.

Parameters:
- NUM_KEYS, 4, number of independent pushbutton channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a level change (10 ms at 50 MHz). Minimum 2.
- CNT_W, 19, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY  in  NUM_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- PRESS  out  NUM_KEYS  one-cycle pulse per accepted press.
- RELEASE  out  NUM_KEYS  one-cycle pulse per accepted release.
- LEVEL  out  NUM_KEYS  debounced pressed state, active-high.
- TOGGLE  out  NUM_KEYS  per-key toggle state.
- LEDG  out  2  both bits = XOR reduction of TOGGLE.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - Synchroniser flops = 1 (released).
  - Counters = 0; FSMs = UP.
  - PRESS, RELEASE, LEVEL, TOGGLE = 0; LEDG = 2'b00.
  - Reset mid-debounce discards the partial count. After release, a key already held low is re-debounced from zero and produces a normal PRESS.
- Synchroniser: two flops per key, no logic between them. Define s = inverted output of the second flop (1 = pressed).
- Per-key FSM, four states:
  - UP: LEVEL = 0. If s = 1, go to WAIT_DOWN with counter = 1.
  - WAIT_DOWN:
    - If s = 0, return to UP with counter = 0 (bounce rejected, no pulse).
    - Else if counter = DEBOUNCE_CYCLES-1, go to DOWN: LEVEL becomes 1, PRESS = 1 for exactly the next cycle, TOGGLE flips.
    - Else counter increments.
  - DOWN: LEVEL = 1. If s = 0, go to WAIT_UP with counter = 1.
  - WAIT_UP: mirror of WAIT_DOWN. On acceptance go to UP: LEVEL becomes 0, RELEASE = 1 for one cycle, TOGGLE unchanged.
- Latency: KEY low sampled at edge 0 gives s = 1 after edge 1. PRESS and LEVEL rise after edge DEBOUNCE_CYCLES+1 and PRESS falls one edge later. Release timing is symmetric.
- Bounce: any reversal of s before the count completes restarts from the stable state. A pulse of DEBOUNCE_CYCLES-1 clocks or shorter never produces PRESS.
- Channels are fully independent. Simultaneous acceptances on several keys in the same cycle each pulse their own PRESS bit.
- TOGGLE and LEDG update in the same cycle as PRESS.
- LEDG: an even number of simultaneous toggles leaves LEDG unchanged, by XOR.
- Counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around path.
- PRESS and RELEASE for one key are never high in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset check: apply reset, KEY=4'hF, release reset -> all outputs 0 and LEDG=00 for 20 cycles.
- Clean press: KEY[0] low at edge 0 and held -> PRESS[0] high only in the cycle after edge 5; LEVEL[0]=1, TOGGLE[0]=1, LEDG=11.
- Bounce rejection: KEY[1] low for 3 cycles, high 1 cycle, low 3 cycles, then high -> no PRESS[1], LEDG unchanged.
- Release and second press: release KEY[0] and hold high -> RELEASE[0] pulse 5 edges later, LEDG still 11. Press again -> TOGGLE[0]=0, LEDG=00.
- Simultaneous press: KEY[2] and KEY[3] low on the same edge -> PRESS[3:2]=11 in the same cycle, TOGGLE[3:2]=11, LEDG unchanged by XOR.
- Mid-debounce reset: KEY[0] low, assert RESET_N at count 2, deassert with KEY[0] still low -> PRESS[0] fires 5 edges after deassertion and TOGGLE[0]=1.

Source files
------------

// File: rtl/key_press_conditioner_if.sv
// Pushbutton front-end bundle: raw keys in, debounced events, state and LEDs out.
interface key_press_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] PRESS;
  logic [NUM_KEYS-1:0] RELEASE;
  logic [NUM_KEYS-1:0] LEVEL;
  logic [NUM_KEYS-1:0] TOGGLE;
  logic [1:0]          LEDG;

  modport master (
    output KEY,
    input  PRESS, RELEASE, LEVEL, TOGGLE, LEDG
  );

  modport slave (
    input  KEY,
    output PRESS, RELEASE, LEVEL, TOGGLE, LEDG
  );
endinterface

// File: rtl/key_press_conditioner.sv
// Synchronises and debounces active-low pushbuttons; emits press/release pulses,
// per-key toggle bits, and drives both green LEDs from the XOR of all toggles.
module key_press_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  key_press_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync_p0;
  logic [NUM_KEYS-1:0] r_sync_p1;
  logic [NUM_KEYS-1:0] w_s;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_toggle;

  // Stage p0/p1: two-flop synchroniser, idles released (high)
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
    end else begin
      r_sync_p0 <= bus.KEY;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_s = ~r_sync_p1;

  // Per-key debounce FSM: counts consecutive stable samples of the new level
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_toggle_nxt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state   <= UP;
        r_cnt     <= CNT_ZERO;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_toggle  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_toggle  <= w_toggle_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_toggle_nxt  = r_toggle;
      case (r_state)
        UP: begin
          if (w_s[k]) begin
            w_state_nxt = WAIT_DOWN;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_DOWN: begin
          if (!w_s[k]) begin
            w_state_nxt = UP;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt  = DOWN;
            w_cnt_nxt    = CNT_ZERO;
            w_press_nxt  = 1'b1;
            w_toggle_nxt = ~r_toggle;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        DOWN: begin
          if (!w_s[k]) begin
            w_state_nxt = WAIT_UP;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_UP: begin
          if (w_s[k]) begin
            w_state_nxt = DOWN;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = UP;
            w_cnt_nxt     = CNT_ZERO;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = UP;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end

    // Pressed state covers DOWN and the pending-release window
    assign w_level[k]   = (r_state == DOWN) || (r_state == WAIT_UP);
    assign w_press[k]   = r_press;
    assign w_release[k] = r_release;
    assign w_toggle[k]  = r_toggle;
  end

  assign bus.PRESS   = w_press;
  assign bus.RELEASE = w_release;
  assign bus.LEVEL   = w_level;
  assign bus.TOGGLE  = w_toggle;
  assign bus.LEDG    = {2{^w_toggle}};

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with a short debounce window.
module tb_key_press_conditioner;

  localparam int NK = 4;

  logic CLOCK_50;
  logic RESET_N;

  key_press_conditioner_if #(.NUM_KEYS(NK)) bus ();

  key_press_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] key;
    int         ticks;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
    logic [3:0] tog;
    logic [1:0] ledg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] l, input logic [3:0] t, input logic [1:0] g);
    chk({tag, ".press"},   32'(bus.PRESS),   32'(p));
    chk({tag, ".release"}, 32'(bus.RELEASE), 32'(r));
    chk({tag, ".level"},   32'(bus.LEVEL),   32'(l));
    chk({tag, ".toggle"},  32'(bus.TOGGLE),  32'(t));
    chk({tag, ".ledg"},    32'(bus.LEDG),    32'(g));
  endtask

  function automatic void add(input logic [3:0] key, input int ticks, input logic [3:0] p,
                              input logic [3:0] r, input logic [3:0] l,
                              input logic [3:0] t, input logic [1:0] g);
    vec_t v;
    v.key = key; v.ticks = ticks; v.press = p; v.rel = r;
    v.level = l; v.tog = t; v.ledg = g;
    vecs.push_back(v);
  endfunction

  initial begin
    // Clean press of key 0: pulse only after the sixth edge from the change
    add(4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    add(4'hE, 1, 4'h1, 4'h0, 4'h1, 4'h1, 2'b11);
    add(4'hE, 1, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    // Key 1 bounces: 3 low, 1 high, 3 low, then released
    add(4'hC, 3, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    add(4'hE, 1, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    add(4'hC, 3, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    add(4'hE, 10, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    // Release key 0, then press again
    add(4'hF, 5, 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);
    add(4'hF, 1, 4'h0, 4'h1, 4'h0, 4'h1, 2'b11);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h1, 2'b11);
    add(4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h1, 2'b11);
    add(4'hE, 1, 4'h1, 4'h0, 4'h1, 4'h0, 2'b00);
    add(4'hE, 1, 4'h0, 4'h0, 4'h1, 4'h0, 2'b00);
    add(4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    // Keys 2 and 3 together: even toggle count leaves LEDG alone
    add(4'h3, 5, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    add(4'h3, 1, 4'hC, 4'h0, 4'hC, 4'hC, 2'b00);
    add(4'h3, 1, 4'h0, 4'h0, 4'hC, 4'hC, 2'b00);
    add(4'hF, 6, 4'h0, 4'hC, 4'h0, 4'hC, 2'b00);
    add(4'hF, 4, 4'h0, 4'h0, 4'h0, 4'hC, 2'b00);
    // Single key 1 press flips LEDG
    add(4'hD, 6, 4'h2, 4'h0, 4'h2, 4'hE, 2'b11);
    add(4'hF, 10, 4'h0, 4'h0, 4'h0, 4'hE, 2'b11);

    RESET_N = 1'b0;
    bus.KEY = 4'hF;
    tick(3);
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk($sformatf("reset_idle%0d", i),
          {bus.PRESS, bus.RELEASE, bus.LEVEL, bus.TOGGLE, 2'b00, bus.LEDG}, 32'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      bus.KEY = vecs[i].key;
      tick(vecs[i].ticks);
      chk_all($sformatf("v%0d", i), vecs[i].press, vecs[i].rel, vecs[i].level,
              vecs[i].tog, vecs[i].ledg);
    end

    // Reset while key 0 is mid-debounce (count 2), key still held afterwards
    bus.KEY = 4'hE;
    tick(4);
    RESET_N = 1'b0;
    #1;
    chk_all("midrst_in", 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    RESET_N = 1'b1;
    tick(5);
    chk_all("midrst_wait", 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    tick(1);
    chk_all("midrst_press", 4'h1, 4'h0, 4'h1, 4'h1, 2'b11);
    tick(1);
    chk_all("midrst_after", 4'h0, 4'h0, 4'h1, 4'h1, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
